clk_period_meter: RTL and testbench
===================================

Name: clk_period_meter

Overview:
Measures an on-chip divided clock (or any slow periodic signal) in units of the fast system clock clk_i. Reports high-phase, low-phase and full-period lengths for each completed period, and flags lock once consecutive periods match. It is the checking end of the clock-divider path: the divider produces clk_o from a div setting, and this block recovers the resulting period for self-test and status registers.

Parameters:
CNT_W, 8, width of the high and low phase counters; saturating.
SYNC_STAGES, 2, synchronizer flops on sig_i (min 2).
LOCK_CNT, 2, consecutive identical periods required to assert lock_o (min 2).

Ports:
clk_i  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
sig_i  input  1  signal to measure (e.g. divided clock); asynchronous-safe.
meas_en  input  1  measurement enable; low forces IDLE.
high_o  output  CNT_W  cycles sig was high in the last completed period.
low_o  output  CNT_W  cycles sig was low in the last completed period.
period_o  output  CNT_W+1  high_o + low_o, full width, no truncation.
valid_o  output  1  one-cycle pulse when high_o/low_o/period_o update.
lock_o  output  1  LOCK_CNT consecutive identical period_o values seen.
overflow_o  output  1  sticky: a phase counter saturated.

Behaviour:
- Reset (rst=1 at clk_i edge): all outputs 0, synchronizer and edge-history flops 0, state IDLE, counters 0, match count 0.
- Synchronizer: sig_i → SYNC_STAGES flops → s; prev_s = s delayed one cycle; rise = s & ~prev_s; fall = ~s & prev_s.
- FSM states: IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW.
- IDLE: meas_en=1 → WAIT_RISE. Counters, match count and overflow_o cleared while in IDLE.
- WAIT_RISE: on rise → MEAS_HIGH, cnt=1. A partial first period is never reported.
- MEAS_HIGH: cnt increments each cycle. On fall: hi_cap=cnt, cnt=1, go to MEAS_LOW. hi_cap therefore equals the number of cycles s was high.
- MEAS_LOW: cnt increments each cycle. On rise: high_o=hi_cap, low_o=cnt, period_o=hi_cap+cnt, valid_o=1 for that cycle, cnt=1, go to MEAS_HIGH.
- Latency: valid_o is registered and asserts SYNC_STAGES+1 clk_i cycles after the raw sig_i rising edge that closes the period.
- Lock logic:
  - Evaluated only on valid cycles; compare the new period against the previous reported period.
  - Equal: match count increments, saturating at LOCK_CNT-1.
  - Different, or the first valid after WAIT_RISE: match count = 0.
  - lock_o = (match count == LOCK_CNT-1), registered, changes only on valid cycles (or on clear).
- Overflow:
  - cnt reaching all-ones in MEAS_HIGH or MEAS_LOW sets overflow_o=1 (sticky), clears lock_o and match count, and sends the FSM to WAIT_RISE.
  - No valid_o pulse is generated for that period.
  - overflow_o clears only on rst or meas_en=0.
- meas_en=0 in any state: next state IDLE. lock_o, overflow_o and the match count clear. high_o/low_o/period_o hold their last values. No valid_o.
- Simultaneous rise/fall: impossible by construction (single s bit).
- Glitch narrower than one clk_i period: may be missed. A one-cycle phase is legal and measured as 1.
- rst mid-measurement: immediate return to reset values; the next measurement restarts from IDLE.

Decomposition:
- Package clk_meter_pkg holds:
  - state enum (IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW);
  - default CNT_W, SYNC_STAGES, LOCK_CNT localparams;
  - counter saturation constant.
- One sub-module, sync_edge_det: synchronizer chain plus prev_s, outputting s, rise and fall. It is reusable for other slow-input status logic.
- FSM, counters and lock logic stay in clk_period_meter.

Test Plan:
- Square wave, sig_i toggling every 4 clk_i cycles, meas_en=1 after reset → first valid_o after one discarded partial period, high_o=4, low_o=4, period_o=8. valid_o repeats every 8 cycles. lock_o=1 at the 2nd valid.
- Duty change: high 3 / low 5 stable, then switch to toggle every 10 → on the first 10/10 period, period_o=20 and lock_o drops. lock_o reasserts on the next valid with period 20.
- Constant sig_i=1 after a rise, CNT_W=8 → overflow_o=1 after 255 cycles in MEAS_HIGH, lock_o=0, no valid_o. overflow_o stays set until meas_en is pulsed low.
- meas_en deasserted mid-MEAS_LOW → next cycle state IDLE, no valid_o, lock_o=0, high_o/low_o hold their values. Re-enable → the first period is discarded, then measurement resumes.
- rst asserted for one cycle while locked at period 8 → all outputs 0 next cycle. After release, a new lock is reached only after the full relock sequence.
- Minimum phases: sig_i toggling every clk_i cycle → high_o=1, low_o=1, period_o=2, valid_o every 2 cycles, lock_o asserted.

Source files
------------

// File: rtl/clk_meter_pkg.sv
// Shared types and defaults for the clock period meter.
package clk_meter_pkg;

  localparam int CNT_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int LOCK_CNT_DEF    = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEAS_HIGH = 2'd2,
    ST_MEAS_LOW  = 2'd3
  } meter_state_t;

  // All-ones value of a phase counter of width w. A counter that reaches this
  // value is treated as saturated.
  function automatic int cnt_sat(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for a slow asynchronous input, with one-cycle
// rise/fall pulses derived from the synchronized level.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_s;

  // Shift the raw input through the synchronizer chain and keep the last
  // synchronized value for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      sync_q <= '0;
      prev_s <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_s <= sync_q[STAGES-1];
    end
  end

  assign s    = sync_q[STAGES-1];
  assign rise = s & ~prev_s;
  assign fall = ~s & prev_s;

endmodule

// File: rtl/clk_period_meter.sv
// Measures high/low/period lengths of a slow signal in clk_i cycles and
// reports lock once consecutive periods match.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ST_IDLE      | disabled; counters, match count and overflow cleared
//   ST_WAIT_RISE | armed; waiting for a rising edge to start a clean period
//   ST_MEAS_HIGH | counting the high phase
//   ST_MEAS_LOW  | counting the low phase; next rise closes and reports period
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int LOCK_CNT    = LOCK_CNT_DEF
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             sig_i,
  input  logic             meas_en,
  output logic [CNT_W-1:0] high_o,
  output logic [CNT_W-1:0] low_o,
  output logic [CNT_W:0]   period_o,
  output logic             valid_o,
  output logic             lock_o,
  output logic             overflow_o
);

  localparam int               MC_W     = $clog2(LOCK_CNT);
  localparam logic [MC_W-1:0]  MC_MAX   = MC_W'(LOCK_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_sat(CNT_W));
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic s, rise, fall;

  meter_state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [CNT_W-1:0] hi_cap, hi_cap_n;
  logic [CNT_W-1:0] high_n, low_n;
  logic [CNT_W:0]   period_n, period_new;
  logic             valid_n, lock_n, ovf_n;
  logic [MC_W-1:0]  mc, mc_n;
  logic             first_v, first_n;
  logic             ovf_hit;

  sync_edge_det #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i(clk_i),
    .rst  (rst),
    .d    (sig_i),
    .s    (s),
    .rise (rise),
    .fall (fall)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      hi_cap     <= '0;
      high_o     <= '0;
      low_o      <= '0;
      period_o   <= '0;
      valid_o    <= 1'b0;
      lock_o     <= 1'b0;
      overflow_o <= 1'b0;
      mc         <= '0;
      first_v    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      hi_cap     <= hi_cap_n;
      high_o     <= high_n;
      low_o      <= low_n;
      period_o   <= period_n;
      valid_o    <= valid_n;
      lock_o     <= lock_n;
      overflow_o <= ovf_n;
      mc         <= mc_n;
      first_v    <= first_n;
    end
  end

  // Next-state, phase counting, period reporting and lock tracking.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    hi_cap_n   = hi_cap;
    high_n     = high_o;
    low_n      = low_o;
    period_n   = period_o;
    valid_n    = 1'b0;
    lock_n     = lock_o;
    ovf_n      = overflow_o;
    mc_n       = mc;
    first_n    = first_v;
    ovf_hit    = 1'b0;
    cnt_inc    = cnt + 1'b1;
    period_new = {1'b0, hi_cap} + {1'b0, cnt};

    if (!meas_en) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      mc_n    = '0;
      lock_n  = 1'b0;
      ovf_n   = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_n   = '0;
          mc_n    = '0;
          lock_n  = 1'b0;
          ovf_n   = 1'b0;
          first_n = 1'b1;
          state_n = ST_WAIT_RISE;
        end
        ST_WAIT_RISE: begin
          if (rise) begin
            cnt_n   = CNT_ONE;
            state_n = ST_MEAS_HIGH;
          end
        end
        ST_MEAS_HIGH: begin
          if (fall) begin
            hi_cap_n = cnt;
            cnt_n    = CNT_ONE;
            state_n  = ST_MEAS_LOW;
          end else if (s) begin
            if (cnt_inc == CNT_MAX) ovf_hit = 1'b1;
            else                    cnt_n   = cnt_inc;
          end
        end
        ST_MEAS_LOW: begin
          if (rise) begin
            valid_n  = 1'b1;
            high_n   = hi_cap;
            low_n    = cnt;
            period_n = period_new;
            cnt_n    = CNT_ONE;
            state_n  = ST_MEAS_HIGH;
            first_n  = 1'b0;
            // The first report after arming has nothing valid to compare to.
            if (!first_v && (period_new == period_o))
              mc_n = (mc == MC_MAX) ? mc : mc + 1'b1;
            else
              mc_n = '0;
            lock_n = (mc_n == MC_MAX);
          end else if (!s) begin
            if (cnt_inc == CNT_MAX) ovf_hit = 1'b1;
            else                    cnt_n   = cnt_inc;
          end
        end
        default: state_n = ST_IDLE;
      endcase

      // A saturated phase abandons the period and re-arms on the next rise.
      if (ovf_hit) begin
        ovf_n   = 1'b1;
        lock_n  = 1'b0;
        mc_n    = '0;
        cnt_n   = '0;
        first_n = 1'b1;
        state_n = ST_WAIT_RISE;
      end
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: stimulus pushes expected reports,
// a monitor pops them whenever valid_o pulses.
module tb_clk_period_meter;

  localparam int CNT_W       = 8;
  localparam int SYNC_STAGES = 2;
  localparam int LOCK_CNT    = 2;

  logic             clk_i   = 1'b0;
  logic             rst     = 1'b1;
  logic             sig_i   = 1'b0;
  logic             meas_en = 1'b0;
  logic [CNT_W-1:0] high_o, low_o;
  logic [CNT_W:0]   period_o;
  logic             valid_o, lock_o, overflow_o;

  typedef struct {
    int h;
    int l;
    int p;
    int lk;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: lock means the current run of identical periods is at
  // least LOCK_CNT long.
  int run_len, prev_p, open_h, open_l, last_h, last_l, last_p;
  bit have_prev, have_open;

  clk_period_meter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .LOCK_CNT   (LOCK_CNT)
  ) dut (
    .clk_i     (clk_i),
    .rst       (rst),
    .sig_i     (sig_i),
    .meas_en   (meas_en),
    .high_o    (high_o),
    .low_o     (low_o),
    .period_o  (period_o),
    .valid_o   (valid_o),
    .lock_o    (lock_o),
    .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every valid_o pulse must match the oldest expected report.
  always @(negedge clk_i) begin
    exp_t e;
    if (valid_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=1 required=0 high=%0d low=%0d", high_o, low_o);
      end else begin
        e = sb_q.pop_front();
        chk("high_o",   int'(high_o),   e.h);
        chk("low_o",    int'(low_o),    e.l);
        chk("period_o", int'(period_o), e.p);
        chk("lock_o",   int'(lock_o),   e.lk);
      end
    end
  end

  task automatic hold(input logic lvl, input int n);
    sig_i = lvl;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic start_seq();
    run_len   = 0;
    have_prev = 1'b0;
    have_open = 1'b0;
  endtask

  // Called at the rise that closes the open period.
  task automatic push_close();
    int p;
    if (have_open) begin
      p = open_h + open_l;
      if (have_prev && p == prev_p) run_len++;
      else                          run_len = 1;
      have_prev = 1'b1;
      prev_p    = p;
      last_h    = open_h;
      last_l    = open_l;
      last_p    = p;
      sb_q.push_back('{open_h, open_l, p, (run_len >= LOCK_CNT) ? 1 : 0});
    end
  endtask

  task automatic drive_period(input int h, input int l);
    push_close();
    hold(1'b1, h);
    hold(1'b0, l);
    open_h    = h;
    open_l    = l;
    have_open = 1'b1;
  endtask

  // Close the last period, then drop meas_en in the middle of a low phase.
  task automatic close_seq();
    push_close();
    have_open = 1'b0;
    hold(1'b1, 2);
    hold(1'b0, 4);
    meas_en = 1'b0;
    @(negedge clk_i);
    chk("dis_lock",     int'(lock_o),     0);
    chk("dis_overflow", int'(overflow_o), 0);
    chk("dis_valid",    int'(valid_o),    0);
    chk("dis_high",     int'(high_o),     last_h);
    chk("dis_low",      int'(low_o),      last_l);
    chk("dis_period",   int'(period_o),   last_p);
    hold(1'b0, 2);
    meas_en = 1'b1;
    hold(1'b0, 4);
    start_seq();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_high"},     int'(high_o),     0);
    chk({tag, "_low"},      int'(low_o),      0);
    chk({tag, "_period"},   int'(period_o),   0);
    chk({tag, "_valid"},    int'(valid_o),    0);
    chk({tag, "_lock"},     int'(lock_o),     0);
    chk({tag, "_overflow"}, int'(overflow_o), 0);
  endtask

  initial begin
    int h, l, ng, rep, waited;
    rst     = 1'b1;
    meas_en = 1'b0;
    sig_i   = 1'b0;
    repeat (3) @(negedge clk_i);
    chk_all_zero("reset");
    rst     = 1'b0;
    meas_en = 1'b1;
    hold(1'b0, 4);
    start_seq();

    // Square wave 4/4: lock at the second report.
    for (int i = 0; i < 5; i++) drive_period(4, 4);
    close_seq();

    // Duty 3/5 then 10/10: lock drops on the first 20, returns on the next.
    for (int i = 0; i < 4; i++) drive_period(3, 5);
    for (int i = 0; i < 3; i++) drive_period(10, 10);
    close_seq();

    // Minimum one-cycle phases.
    for (int i = 0; i < 6; i++) drive_period(1, 1);
    close_seq();

    // Overflow: stuck high after a locked sequence.
    for (int i = 0; i < 3; i++) drive_period(4, 4);
    push_close();
    have_open = 1'b0;
    sig_i = 1'b1;
    repeat (200) @(negedge clk_i);
    chk("ovf_early",  int'(overflow_o), 0);
    repeat (100) @(negedge clk_i);
    chk("ovf_set",    int'(overflow_o), 1);
    chk("ovf_lock",   int'(lock_o),     0);
    hold(1'b0, 10);
    chk("ovf_sticky", int'(overflow_o), 1);
    meas_en = 1'b0;
    @(negedge clk_i);
    chk("ovf_clear",  int'(overflow_o), 0);
    meas_en = 1'b1;
    hold(1'b0, 4);
    start_seq();

    // Reset while locked at period 8, then relock from scratch.
    for (int i = 0; i < 4; i++) drive_period(4, 4);
    push_close();
    have_open = 1'b0;
    hold(1'b1, 4);
    hold(1'b0, 2);
    rst = 1'b1;
    @(negedge clk_i);
    chk_all_zero("midrst");
    rst = 1'b0;
    hold(1'b0, 4);
    start_seq();
    for (int i = 0; i < 4; i++) drive_period(4, 4);
    close_seq();

    // Randomized groups of repeated periods.
    for (int s = 0; s < 6; s++) begin
      ng = $urandom_range(2, 4);
      for (int g = 0; g < ng; g++) begin
        h   = $urandom_range(1, 15);
        l   = $urandom_range(1, 15);
        rep = $urandom_range(1, 4);
        for (int r = 0; r < rep; r++) drive_period(h, l);
      end
      close_seq();
    end

    waited = 0;
    while (sb_q.size() != 0 && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    chk("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
